// File: rtl/count_tick_if.sv
// Control-side signal bundle between the count/tick generator and its neighbours.
interface count_tick_if #(
  parameter int unsigned DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             mode_raw;
  logic             tick;
  logic             dir;
  logic             dir_chg;
  logic [DIV_W-1:0] div_cnt;

  modport master (
    output en, div_val, mode_raw,
    input  tick, dir, dir_chg, div_cnt
  );

  modport slave (
    input  en, div_val, mode_raw,
    output tick, dir, dir_chg, div_cnt
  );
endinterface

// File: rtl/count_tick_gen.sv
// Programmable count-enable strobe plus a debounced direction bit that only changes on tick
// boundaries, so the downstream counter never sees a direction change mid-period.
module count_tick_gen #(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  count_tick_if.slave bus
);

  localparam int unsigned DebW = ($clog2(DEB_CYCLES + 1) < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic             s1_q, s2_q;
  logic             mode_db_q, mode_db_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic             dir_q, dir_d;
  logic             dir_chg_q, dir_chg_d;

  // Divider: >= compare so a lowered div_val wraps immediately instead of overflowing.
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;
    if (bus.en) begin
      if (div_cnt_q >= bus.div_val) begin
        div_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    mode_db_d = mode_db_q;
    deb_cnt_d = deb_cnt_q;
    if (s2_q == mode_db_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebMax) begin
      mode_db_d = s2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DebW'(1);
    end
  end

  // Uses the pre-update mode_db, so a same-cycle debounce result waits for the next tick.
  always_comb begin
    dir_d     = dir_q;
    dir_chg_d = 1'b0;
    if (tick_q) begin
      dir_d     = mode_db_q;
      dir_chg_d = (mode_db_q != dir_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      mode_db_q <= 1'b0;
      deb_cnt_q <= '0;
      dir_q     <= 1'b0;
      dir_chg_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      s1_q      <= bus.mode_raw;
      s2_q      <= s1_q;
      mode_db_q <= mode_db_d;
      deb_cnt_q <= deb_cnt_d;
      dir_q     <= dir_d;
      dir_chg_q <= dir_chg_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.dir     = dir_q;
  assign bus.dir_chg = dir_chg_q;
  assign bus.div_cnt = div_cnt_q;

endmodule

// File: tb/tb_count_tick_gen.sv
// Directed bench for count_tick_gen: vector table for the divider, hand sequences for debounce.
module tb_count_tick_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  count_tick_if #(.DIV_W(8)) bus ();

  count_tick_gen #(.DIV_W(8), .DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] div_val;
    logic       tick;
    logic [7:0] div_cnt;
    logic       dir;
    logic       dir_chg;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] dv, input logic t,
                     input logic [7:0] c, input int rep);
    for (int k = 0; k < rep; k++) vecs.push_back('{r, e, dv, t, c, 1'b0, 1'b0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode_raw = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    bus.en = 1'b0;
    bus.div_val = 8'd0;
    bus.mode_raw = 1'b0;

    // Reset and period 4
    add(1, 0, 3, 0, 0, 1);
    add(0, 1, 3, 0, 1, 1); add(0, 1, 3, 0, 2, 1); add(0, 1, 3, 0, 3, 1); add(0, 1, 3, 1, 0, 1);
    add(0, 1, 3, 0, 1, 1); add(0, 1, 3, 0, 2, 1); add(0, 1, 3, 0, 3, 1); add(0, 1, 3, 1, 0, 1);
    // Enable gating at div_cnt=2, then four enabled edges to the tick
    add(0, 1, 5, 0, 1, 1); add(0, 1, 5, 0, 2, 1);
    add(0, 0, 5, 0, 2, 7);
    add(0, 1, 5, 0, 3, 1); add(0, 1, 5, 0, 4, 1); add(0, 1, 5, 0, 5, 1); add(0, 1, 5, 1, 0, 1);
    // div_val = 0 ticks every enabled cycle
    add(0, 1, 0, 1, 0, 3);
    // Lower 7 -> 2 while at count 5
    add(0, 1, 7, 0, 1, 1); add(0, 1, 7, 0, 2, 1); add(0, 1, 7, 0, 3, 1);
    add(0, 1, 7, 0, 4, 1); add(0, 1, 7, 0, 5, 1);
    add(0, 1, 2, 1, 0, 1);
    add(0, 1, 2, 0, 1, 1); add(0, 1, 2, 0, 2, 1); add(0, 1, 2, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      bus.en = vecs[i].en;
      bus.div_val = vecs[i].div_val;
      step();
      chk($sformatf("row%0d tick", i), 32'(bus.tick), 32'(vecs[i].tick));
      chk($sformatf("row%0d div_cnt", i), 32'(bus.div_cnt), 32'(vecs[i].div_cnt));
      chk($sformatf("row%0d dir", i), 32'(bus.dir), 32'(vecs[i].dir));
      chk($sformatf("row%0d dir_chg", i), 32'(bus.dir_chg), 32'(vecs[i].dir_chg));
    end

    // div_val = 255: period 256 starting from count 0
    bus.div_val = 8'd255;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      step();
      n++;
      if (bus.tick) seen = 1'b1;
    end
    chk("period256 edges", 32'(n), 32'd256);
    chk("period256 div_cnt", 32'(bus.div_cnt), 32'd0);

    // 3-cycle glitch must not move mode_db or dir
    do_reset();
    bus.en = 1'b1;
    bus.div_val = 8'd1;
    step(); step();
    bus.mode_raw = 1'b1;
    step(); step(); step();
    bus.mode_raw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("glitch dir c%0d", k), 32'(bus.dir), 32'd0);
      chk($sformatf("glitch dir_chg c%0d", k), 32'(bus.dir_chg), 32'd0);
    end
    chk("glitch mode_db", 32'(dut.mode_db_q), 32'd0);

    // mode_db lands on a tick cycle: dir takes the old value, new one at next tick (edge 9)
    do_reset();
    bus.en = 1'b1;
    bus.div_val = 8'd1;
    step();
    bus.mode_raw = 1'b1;
    for (int e = 2; e <= 10; e++) begin
      step();
      if (e == 6) chk("simul mode_db e6", 32'(dut.mode_db_q), 32'd0);
      if (e == 7) chk("simul mode_db e7", 32'(dut.mode_db_q), 32'd1);
      chk($sformatf("simul dir e%0d", e), 32'(bus.dir), (e >= 9) ? 32'd1 : 32'd0);
      chk($sformatf("simul dir_chg e%0d", e), 32'(bus.dir_chg), (e == 9) ? 32'd1 : 32'd0);
    end

    // Aligned case (dir at edge 7), then reset mid-debounce
    do_reset();
    bus.en = 1'b1;
    bus.div_val = 8'd1;
    bus.mode_raw = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      if (e == 6) bus.mode_raw = 1'b0;
      if (e == 8) bus.div_val = 8'd7;
      step();
      if (e == 6) chk("align mode_db e6", 32'(dut.mode_db_q), 32'd1);
      chk($sformatf("align dir e%0d", e), 32'(bus.dir), (e >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("align dir_chg e%0d", e), 32'(bus.dir_chg), (e == 7) ? 32'd1 : 32'd0);
    end
    chk("pre-rst div_cnt", 32'(bus.div_cnt), 32'd3);
    chk("pre-rst deb_cnt", 32'(dut.deb_cnt_q), 32'd2);
    rst = 1'b1;
    step();
    chk("mid-rst tick", 32'(bus.tick), 32'd0);
    chk("mid-rst dir", 32'(bus.dir), 32'd0);
    chk("mid-rst dir_chg", 32'(bus.dir_chg), 32'd0);
    chk("mid-rst div_cnt", 32'(bus.div_cnt), 32'd0);
    chk("mid-rst deb_cnt", 32'(dut.deb_cnt_q), 32'd0);
    chk("mid-rst mode_db", 32'(dut.mode_db_q), 32'd0);
    rst = 1'b0;
    bus.mode_raw = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) chk("restart mode_db e5", 32'(dut.mode_db_q), 32'd0);
      if (e == 6) chk("restart mode_db e6", 32'(dut.mode_db_q), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
